// File: rtl/ace_pkg.sv
// ACE snoop opcodes, CRRESP bit positions and the default snoop channel bundles.
package ace_pkg;

    localparam logic [3:0] SNP_READ_ONCE             = 4'b0000;
    localparam logic [3:0] SNP_READ_SHARED           = 4'b0001;
    localparam logic [3:0] SNP_READ_CLEAN            = 4'b0010;
    localparam logic [3:0] SNP_READ_NOT_SHARED_DIRTY = 4'b0011;
    localparam logic [3:0] SNP_READ_UNIQUE           = 4'b0111;
    localparam logic [3:0] SNP_CLEAN_SHARED          = 4'b1000;
    localparam logic [3:0] SNP_CLEAN_INVALID         = 4'b1001;
    localparam logic [3:0] SNP_MAKE_INVALID          = 4'b1101;

    localparam int CR_DT  = 0;
    localparam int CR_ERR = 1;
    localparam int CR_PD  = 2;
    localparam int CR_IS  = 3;
    localparam int CR_WU  = 4;

    localparam int ACE_ADDR_W = 64;
    localparam int ACE_DATA_W = 64;

    typedef struct packed {
        logic [ACE_ADDR_W-1:0] addr;
        logic [3:0]            snoop;
        logic [2:0]            prot;
    } ac_chan_t;

    typedef struct packed {
        logic     ac_valid;
        ac_chan_t ac;
        logic     cr_ready;
        logic     cd_ready;
    } snoop_req_t;

    typedef struct packed {
        logic [ACE_DATA_W-1:0] data;
        logic                  last;
    } cd_chan_t;

    typedef struct packed {
        logic     ac_ready;
        logic     cr_valid;
        logic [4:0] cr_resp;
        logic     cd_valid;
        cd_chan_t cd;
    } snoop_resp_t;

    function automatic logic snoop_supported(input logic [3:0] snoop);
        case (snoop)
            SNP_READ_ONCE, SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NOT_SHARED_DIRTY,
            SNP_READ_UNIQUE, SNP_CLEAN_SHARED, SNP_CLEAN_INVALID, SNP_MAKE_INVALID:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ace_snoop_resp_decode.sv
// Maps snoop opcode plus tag lookup result to CRRESP and the new cache line state.
module ace_snoop_resp_decode
    import ace_pkg::*;
(
    input  logic [3:0] snoop,
    input  logic       hit,
    input  logic       dirty,
    input  logic       shared,
    output logic [4:0] cr_resp,
    output logic       upd_req,
    output logic       upd_inval,
    output logic       upd_clean,
    output logic       upd_shared
);

    always_comb begin
        cr_resp    = '0;
        upd_req    = 1'b0;
        upd_inval  = 1'b0;
        upd_clean  = 1'b0;
        upd_shared = 1'b0;
        // A miss or an unknown opcode answers with an all-zero response and leaves the line alone.
        if (hit && snoop_supported(snoop)) begin
            cr_resp[CR_WU] = !shared;
            case (snoop)
                SNP_READ_ONCE: begin
                    cr_resp[CR_DT] = 1'b1;
                    cr_resp[CR_IS] = 1'b1;
                end
                SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NOT_SHARED_DIRTY: begin
                    cr_resp[CR_DT] = 1'b1;
                    cr_resp[CR_PD] = dirty;
                    cr_resp[CR_IS] = 1'b1;
                    upd_req        = 1'b1;
                    upd_shared     = 1'b1;
                    upd_clean      = 1'b1;
                end
                SNP_READ_UNIQUE: begin
                    cr_resp[CR_DT] = 1'b1;
                    cr_resp[CR_PD] = dirty;
                    upd_req        = 1'b1;
                    upd_inval      = 1'b1;
                end
                SNP_CLEAN_INVALID: begin
                    cr_resp[CR_DT] = dirty;
                    cr_resp[CR_PD] = dirty;
                    upd_req        = 1'b1;
                    upd_inval      = 1'b1;
                end
                SNP_CLEAN_SHARED: begin
                    cr_resp[CR_DT] = dirty;
                    cr_resp[CR_PD] = dirty;
                    cr_resp[CR_IS] = 1'b1;
                    upd_req        = dirty;
                    upd_clean      = dirty;
                end
                SNP_MAKE_INVALID: begin
                    upd_req        = 1'b1;
                    upd_inval      = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ace_snoop_responder.sv
// Single-outstanding ACE snoop responder: AC accept, tag lookup, CR response,
// line data streamed beat by beat on CD, then the cache line state update.
module ace_snoop_responder
    import ace_pkg::*;
#(
    parameter int unsigned AxiAddrWidth    = ACE_ADDR_W,
    parameter int unsigned AxiDataWidth    = ACE_DATA_W,
    parameter int unsigned DcacheLineWidth = 256,
    parameter type snoop_req_t  = ace_pkg::snoop_req_t,
    parameter type snoop_resp_t = ace_pkg::snoop_resp_t,
    localparam int BeatsPerLine = (DcacheLineWidth / AxiDataWidth) < 1 ? 1 : int'(DcacheLineWidth / AxiDataWidth),
    localparam int BeatW        = BeatsPerLine > 1 ? $clog2(BeatsPerLine) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  snoop_req_t              snoop_req_i,
    output snoop_resp_t             snoop_resp_o,
    output logic                    lookup_valid_o,
    input  logic                    lookup_ready_i,
    output logic [AxiAddrWidth-1:0] lookup_addr_o,
    input  logic                    lookup_hit_i,
    input  logic                    lookup_dirty_i,
    input  logic                    lookup_shared_i,
    output logic                    data_req_o,
    output logic [BeatW-1:0]        data_beat_o,
    input  logic [AxiDataWidth-1:0] data_rdata_i,
    output logic                    upd_valid_o,
    input  logic                    upd_ready_i,
    output logic                    upd_inval_o,
    output logic                    upd_clean_o,
    output logic                    upd_shared_o,
    output logic [2:0]              dbg_state
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOOKUP = 3'd1;
    localparam logic [2:0] ST_RESP   = 3'd2;
    localparam logic [2:0] ST_DRD    = 3'd3;
    localparam logic [2:0] ST_DWR    = 3'd4;
    localparam logic [2:0] ST_UPDATE = 3'd5;

    localparam logic [BeatW-1:0] LastBeat = BeatW'(BeatsPerLine - 1);

    logic [2:0]              state_q;
    logic [BeatW-1:0]        beat_q;
    logic                    rd_wait_q;
    logic [AxiAddrWidth-1:0] addr_q;
    logic [3:0]              snoop_q;
    logic [4:0]              cr_resp_q;
    logic                    upd_req_q, inval_q, clean_q, shared_q;
    logic [AxiDataWidth-1:0] cd_data_q;

    logic [4:0] dec_cr_resp;
    logic       dec_upd_req, dec_inval, dec_clean, dec_shared;
    logic       unused_prot;

    assign unused_prot = ^snoop_req_i.ac.prot;

    ace_snoop_resp_decode u_decode (
        .snoop      (snoop_q),
        .hit        (lookup_hit_i),
        .dirty      (lookup_dirty_i),
        .shared     (lookup_shared_i),
        .cr_resp    (dec_cr_resp),
        .upd_req    (dec_upd_req),
        .upd_inval  (dec_inval),
        .upd_clean  (dec_clean),
        .upd_shared (dec_shared)
    );

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid and its payload never change while the partner holds ready low.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            rd_wait_q <= 1'b0;
            addr_q    <= '0;
            snoop_q   <= '0;
            cr_resp_q <= '0;
            upd_req_q <= 1'b0;
            inval_q   <= 1'b0;
            clean_q   <= 1'b0;
            shared_q  <= 1'b0;
            cd_data_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (snoop_req_i.ac_valid) begin
                    addr_q  <= snoop_req_i.ac.addr[AxiAddrWidth-1:0];
                    snoop_q <= snoop_req_i.ac.snoop;
                    state_q <= ST_LOOKUP;
                end
                ST_LOOKUP: if (lookup_ready_i) begin
                    cr_resp_q <= dec_cr_resp;
                    upd_req_q <= dec_upd_req;
                    inval_q   <= dec_inval;
                    clean_q   <= dec_clean;
                    shared_q  <= dec_shared;
                    state_q   <= ST_RESP;
                end
                ST_RESP: if (snoop_req_i.cr_ready) begin
                    if (cr_resp_q[CR_DT])  state_q <= ST_DRD;
                    else if (upd_req_q)    state_q <= ST_UPDATE;
                    else                   state_q <= ST_IDLE;
                end
                // First DRD cycle issues the read, second captures the data that arrives a cycle later.
                ST_DRD: begin
                    if (!rd_wait_q) begin
                        rd_wait_q <= 1'b1;
                    end else begin
                        rd_wait_q <= 1'b0;
                        cd_data_q <= data_rdata_i;
                        state_q   <= ST_DWR;
                    end
                end
                ST_DWR: if (snoop_req_i.cd_ready) begin
                    if (beat_q == LastBeat) begin
                        beat_q  <= '0;
                        state_q <= upd_req_q ? ST_UPDATE : ST_IDLE;
                    end else begin
                        beat_q  <= beat_q + 1'b1;
                        state_q <= ST_DRD;
                    end
                end
                ST_UPDATE: if (upd_ready_i) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        snoop_resp_o          = '0;
        snoop_resp_o.ac_ready = (state_q == ST_IDLE) && !rst_i;
        snoop_resp_o.cr_valid = (state_q == ST_RESP);
        snoop_resp_o.cr_resp  = cr_resp_q;
        snoop_resp_o.cd_valid = (state_q == ST_DWR);
        snoop_resp_o.cd.data  = cd_data_q;
        snoop_resp_o.cd.last  = (state_q == ST_DWR) && (beat_q == LastBeat);
    end

    assign lookup_valid_o = (state_q == ST_LOOKUP);
    assign lookup_addr_o  = addr_q;
    assign data_req_o     = (state_q == ST_DRD) && !rd_wait_q;
    assign data_beat_o    = beat_q;
    assign upd_valid_o    = (state_q == ST_UPDATE);
    assign upd_inval_o    = inval_q;
    assign upd_clean_o    = clean_q;
    assign upd_shared_o   = shared_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Directed bench for ace_snoop_responder with an expected-queue scoreboard on CR, CD and update.
module tb_ace_snoop_responder;
    import ace_pkg::*;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int LW = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;

    snoop_req_t  req;
    snoop_resp_t resp;
    logic          ac_valid, cr_ready, cd_ready;
    logic [AW-1:0] ac_addr;
    logic [3:0]    ac_snoop;
    logic          lookup_valid, lookup_ready, lookup_hit, lookup_dirty, lookup_shared;
    logic [AW-1:0] lookup_addr;
    logic          data_req;
    logic [1:0]    data_beat;
    logic [DW-1:0] data_rdata;
    logic          upd_valid, upd_ready, upd_inval, upd_clean, upd_shared;
    logic [2:0]    dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cd_hs   = 0;
    int cr_hold = 0;
    bit stall_mode = 1'b0;
    logic [AW-1:0] cur_addr = '0;

    logic [4:0]  exp_cr_q[$];
    logic [DW:0] exp_cd_q[$];
    logic [2:0]  exp_upd_q[$];

    always_comb begin
        req          = '0;
        req.ac_valid = ac_valid;
        req.ac.addr  = ac_addr;
        req.ac.snoop = ac_snoop;
        req.cr_ready = cr_ready;
        req.cd_ready = cd_ready;
    end

    ace_snoop_responder #(
        .AxiAddrWidth    (AW),
        .AxiDataWidth    (DW),
        .DcacheLineWidth (LW),
        .snoop_req_t     (snoop_req_t),
        .snoop_resp_t    (snoop_resp_t)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .snoop_req_i     (req),
        .snoop_resp_o    (resp),
        .lookup_valid_o  (lookup_valid),
        .lookup_ready_i  (lookup_ready),
        .lookup_addr_o   (lookup_addr),
        .lookup_hit_i    (lookup_hit),
        .lookup_dirty_i  (lookup_dirty),
        .lookup_shared_i (lookup_shared),
        .data_req_o      (data_req),
        .data_beat_o     (data_beat),
        .data_rdata_i    (data_rdata),
        .upd_valid_o     (upd_valid),
        .upd_ready_i     (upd_ready),
        .upd_inval_o     (upd_inval),
        .upd_clean_o     (upd_clean),
        .upd_shared_o    (upd_shared),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input logic [1:0] b);
        return {8'hCD, 22'h0, b, a[31:0]};
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    // ---------------- line data memory model ----------------
    initial begin
        logic       req_s;
        logic [1:0] beat_s;
        data_rdata = '0;
        forever begin
            @(negedge clk);
            req_s  = data_req;
            beat_s = data_beat;
            @(posedge clk);
            #1;
            data_rdata = req_s ? pat(cur_addr, beat_s) : {$urandom, $urandom};
        end
    end

    // ---------------- ready drivers ----------------
    initial begin
        cr_ready  = 1'b1;
        cd_ready  = 1'b1;
        upd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_mode) begin
                if (resp.cr_valid && cr_hold < 5) begin
                    cr_ready = 1'b0;
                    cr_hold++;
                end else begin
                    cr_ready = 1'b1;
                end
                cd_ready  = ~cd_ready;
                upd_ready = ~upd_ready;
            end else begin
                cr_ready  = 1'b1;
                cd_ready  = 1'b1;
                upd_ready = 1'b1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic        prev_cr_stall, prev_cd_stall;
        logic [4:0]  prev_cr;
        logic [DW:0] prev_cd;
        prev_cr_stall = 1'b0;
        prev_cd_stall = 1'b0;
        prev_cr = '0;
        prev_cd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_cr_stall = 1'b0;
                prev_cd_stall = 1'b0;
            end else begin
                if (prev_cr_stall) begin
                    check("cr_valid_held", 65'(resp.cr_valid), 65'(1));
                    check("cr_resp_stable", 65'(resp.cr_resp), 65'(prev_cr));
                end
                if (prev_cd_stall) begin
                    check("cd_valid_held", 65'(resp.cd_valid), 65'(1));
                    check("cd_stable", 65'({resp.cd.last, resp.cd.data}), 65'(prev_cd));
                end
                prev_cr_stall = resp.cr_valid && !cr_ready;
                prev_cd_stall = resp.cd_valid && !cd_ready;
                prev_cr = resp.cr_resp;
                prev_cd = {resp.cd.last, resp.cd.data};
                if (resp.cr_valid && cr_ready) begin
                    if (exp_cr_q.size() == 0) fail_now("cr_unexpected");
                    else check("cr_resp", 65'(resp.cr_resp), 65'(exp_cr_q.pop_front()));
                end
                if (resp.cd_valid && cd_ready) begin
                    cd_hs++;
                    if (exp_cd_q.size() == 0) fail_now("cd_unexpected");
                    else check("cd_beat", 65'({resp.cd.last, resp.cd.data}), 65'(exp_cd_q.pop_front()));
                end
                if (upd_valid && upd_ready) begin
                    if (exp_upd_q.size() == 0) fail_now("upd_unexpected");
                    else check("upd_state", 65'({upd_inval, upd_clean, upd_shared}), 65'(exp_upd_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_cr_q.size() == 0 && exp_cd_q.size() == 0 && exp_upd_q.size() == 0 && resp.ac_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("txn_done_in_budget", 65'(ok), 65'(1));
    endtask

    task automatic issue(input logic [3:0] op, input logic [AW-1:0] addr,
                         input logic hit, input logic dirty, input logic shared,
                         input logic [4:0] exp_cr, input int beats,
                         input logic has_upd, input logic [2:0] exp_upd,
                         input bit chk_ac, input bit wait_done);
        bit ok;
        exp_cr_q.push_back(exp_cr);
        for (int b = 0; b < beats; b++)
            exp_cd_q.push_back({(b == beats - 1), pat(addr, 2'(b))});
        if (has_upd) exp_upd_q.push_back(exp_upd);
        cur_addr = addr;

        @(posedge clk);
        #1;
        ac_valid = 1'b1;
        ac_addr  = addr;
        ac_snoop = op;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (resp.ac_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("ac_handshake", 65'(ok), 65'(1));
        @(posedge clk);
        #1;
        ac_valid = 1'b0;
        ac_addr  = {$urandom, $urandom};
        ac_snoop = 4'($urandom);

        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (lookup_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("lookup_valid", 65'(ok), 65'(1));
        check("lookup_addr", 65'(lookup_addr), 65'(addr));
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(posedge clk);
        #1;
        lookup_ready  = 1'b1;
        lookup_hit    = hit;
        lookup_dirty  = dirty;
        lookup_shared = shared;
        @(posedge clk);
        #1;
        lookup_ready  = 1'b0;
        lookup_hit    = 1'($urandom);
        lookup_dirty  = 1'($urandom);
        lookup_shared = 1'($urandom);

        if (chk_ac) begin
            ok = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (resp.cr_valid && cr_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("cr_seen", 65'(ok), 65'(1));
            @(negedge clk);
            check("ac_ready_after_cr", 65'(resp.ac_ready), 65'(1));
        end
        if (wait_done) wait_idle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        ac_valid = 1'b0;
        ac_addr  = '0;
        ac_snoop = '0;
        lookup_ready  = 1'b0;
        lookup_hit    = 1'b0;
        lookup_dirty  = 1'b0;
        lookup_shared = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ac_ready", 65'(resp.ac_ready), 65'(0));
        check("rst_cr_valid", 65'(resp.cr_valid), 65'(0));
        check("rst_cr_resp", 65'(resp.cr_resp), 65'(0));
        check("rst_cd_valid", 65'(resp.cd_valid), 65'(0));
        check("rst_cd", 65'({resp.cd.last, resp.cd.data}), 65'(0));
        check("rst_lookup_valid", 65'(lookup_valid), 65'(0));
        check("rst_data_req", 65'(data_req), 65'(0));
        check("rst_upd_valid", 65'(upd_valid), 65'(0));
        check("rst_state", 65'(dbg_state), 65'(0));
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("ac_ready_after_rst", 65'(resp.ac_ready), 65'(1));

        issue(SNP_READ_SHARED,           64'h1000, 1, 1, 1, 5'b01101, 4, 1, 3'b011, 0, 1);
        issue(SNP_READ_UNIQUE,           64'h2040, 1, 0, 0, 5'b10001, 4, 1, 3'b100, 0, 1);
        issue(SNP_MAKE_INVALID,          64'h3080, 1, 1, 0, 5'b10000, 0, 1, 3'b100, 0, 1);
        issue(SNP_READ_SHARED,           64'h40C0, 0, 1, 0, 5'b00000, 0, 0, 3'b000, 1, 1);
        issue(SNP_CLEAN_INVALID,         64'h5000, 0, 1, 1, 5'b00000, 0, 0, 3'b000, 1, 1);
        issue(SNP_READ_ONCE,             64'h6040, 1, 0, 1, 5'b01001, 4, 0, 3'b000, 0, 1);
        issue(SNP_CLEAN_SHARED,          64'h7080, 1, 1, 0, 5'b11101, 4, 1, 3'b010, 0, 1);
        issue(SNP_CLEAN_SHARED,          64'h80C0, 1, 0, 1, 5'b01000, 0, 0, 3'b000, 0, 1);
        issue(SNP_CLEAN_INVALID,         64'h9000, 1, 1, 0, 5'b10101, 4, 1, 3'b100, 0, 1);
        issue(4'b1011,                   64'hA040, 1, 1, 0, 5'b00000, 0, 0, 3'b000, 1, 1);
        issue(SNP_READ_NOT_SHARED_DIRTY, 64'hB080, 1, 0, 0, 5'b11001, 4, 1, 3'b011, 0, 1);

        // Back-pressure: CR held off for five cycles, CD and update ready toggling.
        cr_hold    = 0;
        stall_mode = 1'b1;
        issue(SNP_READ_SHARED,           64'hC0C0, 1, 1, 0, 5'b11101, 4, 1, 3'b011, 0, 1);
        stall_mode = 1'b0;
        check("stall_cr_cycles", 65'(cr_hold), 65'(5));

        // Reset while beat 2 is being fetched aborts the rest of the line and the update.
        cd_hs = 0;
        issue(SNP_READ_SHARED,           64'hD000, 1, 1, 0, 5'b11101, 4, 1, 3'b011, 0, 0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cd_hs >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        check("two_beats_before_rst", 65'(ok), 65'(1));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_cr_valid", 65'(resp.cr_valid), 65'(0));
        check("abort_cd_valid", 65'(resp.cd_valid), 65'(0));
        check("abort_upd_valid", 65'(upd_valid), 65'(0));
        check("abort_data_req", 65'(data_req), 65'(0));
        check("abort_ac_ready", 65'(resp.ac_ready), 65'(0));
        check("abort_state", 65'(dbg_state), 65'(0));
        exp_cr_q.delete();
        exp_cd_q.delete();
        exp_upd_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("ac_ready_after_abort", 65'(resp.ac_ready), 65'(1));
        issue(SNP_READ_CLEAN,            64'hE040, 1, 0, 1, 5'b01001, 4, 1, 3'b011, 0, 1);

        repeat (5) @(negedge clk);
        check("leftover_expected", 65'(exp_cr_q.size() + exp_cd_q.size() + exp_upd_q.size()), 65'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
